// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter sharing one UART transmitter between byte producers.
// Supports packet locking and flags a sticky error if a frame never starts.
module uart_tx_arbiter #(
    parameter int N_REQ         = 4,
    parameter int DATA_WIDTH    = 8,
    parameter int START_TIMEOUT = 16
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic [N_REQ-1:0]              req_valid,
    input  logic [N_REQ*DATA_WIDTH-1:0]   req_data,
    input  logic [N_REQ-1:0]              req_last,
    output logic [N_REQ-1:0]              req_ready,
    output logic                          tx_sending,
    output logic [DATA_WIDTH-1:0]         tx_data,
    input  logic                          tx_busy,
    output logic [$clog2(N_REQ)-1:0]      grant_id,
    output logic                          active,
    output logic                          locked,
    output logic                          error
);

    localparam int IW = $clog2(N_REQ);
    localparam int CW = $clog2(START_TIMEOUT + 1);

    typedef enum logic [1:0] {
        IDLE,
        START,
        WAIT_BUSY,
        WAIT_DONE
    } state_t;

    state_t                state;
    state_t                state_next;
    logic [IW-1:0]         rr;
    logic [IW-1:0]         win;
    logic                  win_found;
    logic [DATA_WIDTH-1:0] win_data;
    logic [CW-1:0]         cnt;
    logic                  accept;
    logic                  timeout;

    // Last assignment wins, so scanning downward leaves the index closest
    // to the round-robin pointer as the winner.
    always_comb begin
        int            idx;
        logic [IW-1:0] cand;
        idx       = 0;
        cand      = '0;
        win       = grant_id;
        win_found = 1'b0;
        if (locked) begin
            win_found = req_valid[grant_id];
        end else begin
            for (int i = N_REQ - 1; i >= 0; i--) begin
                idx = int'(rr) + i;
                if (idx >= N_REQ) idx = idx - N_REQ;
                cand = IW'(idx);
                if (req_valid[cand]) begin
                    win_found = 1'b1;
                    win       = cand;
                end
            end
        end
    end

    always_comb begin
        win_data = '0;
        for (int i = 0; i < N_REQ; i++) begin
            if (win == IW'(i)) win_data = req_data[i*DATA_WIDTH +: DATA_WIDTH];
        end
    end

    assign timeout = (state == WAIT_BUSY) && !tx_busy &&
                     (cnt == CW'(START_TIMEOUT - 1));

    always_comb begin
        state_next = state;
        req_ready  = '0;
        accept     = 1'b0;
        unique case (state)
            IDLE: begin
                if (!tx_busy && win_found && !reset) begin
                    accept         = 1'b1;
                    req_ready[win] = 1'b1;
                    state_next     = START;
                end
            end
            START:     state_next = WAIT_BUSY;
            WAIT_BUSY: begin
                if (tx_busy)      state_next = WAIT_DONE;
                else if (timeout) state_next = IDLE;
            end
            WAIT_DONE: begin
                if (!tx_busy) state_next = IDLE;
            end
            default:   state_next = IDLE;
        endcase
    end

    assign tx_sending = (state == START);

    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= IDLE;
            rr       <= '0;
            cnt      <= '0;
            tx_data  <= '0;
            grant_id <= '0;
            active   <= 1'b0;
            locked   <= 1'b0;
            error    <= 1'b0;
        end else begin
            state <= state_next;
            if (accept) begin
                tx_data  <= win_data;
                grant_id <= win;
                rr       <= (win == IW'(N_REQ - 1)) ? '0 : win + IW'(1);
                locked   <= !req_last[win];
                active   <= 1'b1;
            end
            if (state == START) cnt <= '0;
            if (state == WAIT_BUSY && !tx_busy) cnt <= cnt + CW'(1);
            // A frame that never starts is dropped and the lock released.
            if (timeout) begin
                error  <= 1'b1;
                active <= 1'b0;
                locked <= 1'b0;
            end
            if (state == WAIT_DONE && !tx_busy) active <= 1'b0;
        end
    end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Bench for uart_tx_arbiter: directed scenarios plus random traffic,
// every cycle compared against a transaction-level reference model.
module tb_uart_tx_arbiter;

    localparam int N = 4;
    localparam int W = 8;
    localparam int T = 16;

    logic           clk = 1'b0;
    logic           reset;
    logic [N-1:0]   req_valid;
    logic [N*W-1:0] req_data;
    logic [N-1:0]   req_last;
    logic [N-1:0]   req_ready;
    logic           tx_sending;
    logic [W-1:0]   tx_data;
    logic           tx_busy;
    logic [1:0]     grant_id;
    logic           active;
    logic           locked;
    logic           error;

    always #5 clk = ~clk;

    uart_tx_arbiter #(.N_REQ(N), .DATA_WIDTH(W), .START_TIMEOUT(T)) dut (
        .clk(clk), .reset(reset),
        .req_valid(req_valid), .req_data(req_data), .req_last(req_last),
        .req_ready(req_ready), .tx_sending(tx_sending), .tx_data(tx_data),
        .tx_busy(tx_busy), .grant_id(grant_id), .active(active),
        .locked(locked), .error(error)
    );

    int checks = 0;
    int failures = 0;

    task automatic chk(string name, int act, int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic expire(string name);
        checks++;
        failures++;
        $display("FAIL %s: event never happened within its cycle budget", name);
    endtask

    // Reference model: transaction phases tracked with plain counters.
    int       m_rr = 0, m_gid = 0, m_wait = -1, m_acc_w = -1;
    bit       m_lock = 0, m_act = 0, m_err = 0, m_send = 0, m_inframe = 0;
    bit [7:0] m_data = 0;
    bit       check_en = 0;

    function automatic int pick();
        if (m_send || m_wait >= 0 || m_inframe || tx_busy || reset) return -1;
        if (m_lock) return req_valid[m_gid] ? m_gid : -1;
        for (int k = 0; k < N; k++) begin
            int j;
            j = (m_rr + k) % N;
            if (req_valid[j]) return j;
        end
        return -1;
    endfunction

    always @(posedge clk) begin : model
        int w;
        w = pick();
        m_acc_w = -1;
        if (reset) begin
            m_rr = 0; m_gid = 0; m_wait = -1; m_lock = 0; m_act = 0;
            m_err = 0; m_send = 0; m_inframe = 0; m_data = 0;
        end else if (m_send) begin
            m_send = 0;
            m_wait = 0;
        end else if (m_wait >= 0) begin
            if (tx_busy) begin
                m_wait = -1;
                m_inframe = 1;
            end else if (m_wait == T - 1) begin
                m_err = 1; m_act = 0; m_lock = 0; m_wait = -1;
            end else begin
                m_wait++;
            end
        end else if (m_inframe) begin
            if (!tx_busy) begin
                m_inframe = 0;
                m_act = 0;
            end
        end else if (w >= 0) begin
            m_acc_w = w;
            m_data  = req_data[w*W +: W];
            m_gid   = w;
            m_rr    = (w + 1) % N;
            m_lock  = !req_last[w];
            m_act   = 1;
            m_send  = 1;
        end
    end

    int       ncyc = 0, send_cyc = 0, err_cyc = 0;
    bit       saw_send = 0, err_seen = 0, err_prev = 0;
    int       grants[$];
    int       bytes[$];
    int       lockq[$];

    always @(negedge clk) begin : compare
        int w;
        ncyc++;
        saw_send = (tx_sending === 1'b1);
        for (int k = 0; k < N; k++)
            if (req_ready[k] === 1'b1 && req_valid[k]) grants.push_back(k);
        if (tx_sending === 1'b1) begin
            bytes.push_back(int'(tx_data));
            lockq.push_back(int'(locked));
            send_cyc = ncyc;
        end
        if (error === 1'b1 && !err_prev) begin
            err_seen = 1;
            err_cyc  = ncyc;
        end
        err_prev = (error === 1'b1);
        if (check_en) begin
            w = pick();
            chk("req_ready", int'(req_ready), w >= 0 ? (1 << w) : 0);
            chk("tx_sending", int'(tx_sending), int'(m_send));
            chk("tx_data", int'(tx_data), int'(m_data));
            chk("grant_id", int'(grant_id), m_gid);
            chk("active", int'(active), int'(m_act));
            chk("locked", int'(locked), int'(m_lock));
            chk("error", int'(error), int'(m_err));
        end
    end

    // Transmitter model and random requester traffic.
    int tx_dly = 0, tx_len = 0, tx_len_fix = 0;
    bit dead_mode = 0, rand_dead = 0, rand_req = 0;

    task automatic tx_drive();
        if (saw_send) begin
            if (dead_mode || (rand_dead && $urandom_range(0, 15) == 0)) begin
                tx_dly = 0;
                tx_len = 0;
            end else begin
                tx_dly = $urandom_range(0, 2);
                tx_len = (tx_len_fix > 0) ? tx_len_fix : $urandom_range(1, 4);
            end
        end
        if (tx_dly > 0) begin
            tx_dly--;
            tx_busy = 1'b0;
        end else if (tx_len > 0) begin
            tx_len--;
            tx_busy = 1'b1;
        end else begin
            tx_busy = 1'b0;
        end
    endtask

    task automatic set_req(int i, logic [7:0] d, logic l);
        req_valid[i]       = 1'b1;
        req_data[i*W +: W] = d;
        req_last[i]        = l;
    endtask

    task automatic req_rand();
        reset = ($urandom_range(0, 299) == 0);
        for (int i = 0; i < N; i++) begin
            if (m_acc_w == i) begin
                if ($urandom_range(0, 1) == 0) req_valid[i] = 1'b0;
                else set_req(i, 8'($urandom), $urandom_range(0, 3) != 0);
            end else if (!req_valid[i]) begin
                if ($urandom_range(0, 3) == 0)
                    set_req(i, 8'($urandom), $urandom_range(0, 3) != 0);
            end else if ($urandom_range(0, 39) == 0) begin
                req_valid[i] = 1'b0;
            end
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        tx_drive();
        if (rand_req) req_rand();
    endtask

    task automatic wait_idle(string name);
        int n;
        n = 0;
        while ((active || tx_busy) && n < 200) begin
            step();
            n++;
        end
        if (n >= 200) expire(name);
    endtask

    task automatic do_reset();
        reset = 1'b1;
        req_valid = '0;
        step();
        step();
        reset = 1'b0;
    endtask

    // Steps until n grants are recorded; accepted requesters either drop
    // valid or, with refresh set, present a new byte.
    task automatic run_until(int n, bit refresh, string name);
        int k;
        k = 0;
        while (grants.size() < n && k < 300) begin
            step();
            if (m_acc_w >= 0) begin
                if (refresh) req_data[m_acc_w*W +: W] = 8'($urandom);
                else req_valid[m_acc_w] = 1'b0;
            end
            k++;
        end
        if (k >= 300) expire(name);
    endtask

    initial begin
        int k;
        int exp_rr[5];
        reset = 1'b1; req_valid = '0; req_data = '0; req_last = '0; tx_busy = 1'b0;
        step();
        check_en = 1;
        step();
        reset = 1'b0;
        @(negedge clk);
        chk("rst_ready", int'(req_ready), 0);
        chk("rst_grant", int'(grant_id), 0);
        chk("rst_error", int'(error), 0);
        chk("rst_active", int'(active), 0);

        // single byte from requester 2
        step();
        set_req(2, 8'hA5, 1'b1);
        @(negedge clk);
        chk("single_ready", int'(req_ready), 4);
        step();
        req_valid = '0;
        @(negedge clk);
        chk("single_send", int'(tx_sending), 1);
        chk("single_data", int'(tx_data), 'hA5);
        chk("single_gid", int'(grant_id), 2);
        chk("single_lock", int'(locked), 0);
        chk("model_single", int'(m_data), 'hA5);
        wait_idle("single_done");

        // round robin from reset
        do_reset();
        grants.delete();
        for (int i = 0; i < N; i++) set_req(i, 8'($urandom), 1'b1);
        run_until(5, 1, "rr_grants");
        req_valid = '0;
        exp_rr = '{0, 1, 2, 3, 0};
        for (int i = 0; i < 5; i++)
            if (i < grants.size()) chk($sformatf("rr_order%0d", i), grants[i], exp_rr[i]);
        wait_idle("rr_done");

        // wrap-around after granting 3
        do_reset();
        grants.delete();
        set_req(3, 8'h33, 1'b1);
        run_until(1, 0, "wrap_first");
        set_req(0, 8'h30, 1'b1);
        set_req(1, 8'h31, 1'b1);
        run_until(2, 0, "wrap_second");
        req_valid = '0;
        if (grants.size() >= 2) begin
            chk("wrap_g0", grants[0], 3);
            chk("wrap_g1", grants[1], 0);
        end
        wait_idle("wrap_done");

        // packet lock: pointer now at 1
        bytes.delete();
        lockq.delete();
        set_req(1, 8'h11, 1'b0);
        set_req(0, 8'hC0, 1'b1);
        k = 0;
        while (bytes.size() < 3 && k < 300) begin
            step();
            if (m_acc_w == 1 && !req_last[1]) set_req(1, 8'h22, 1'b1);
            else if (m_acc_w >= 0) req_valid[m_acc_w] = 1'b0;
            k++;
        end
        if (k >= 300) expire("lock_bytes");
        if (bytes.size() >= 3) begin
            chk("lock_b0", bytes[0], 'h11);
            chk("lock_b1", bytes[1], 'h22);
            chk("lock_b2", bytes[2], 'hC0);
            chk("lock_l0", lockq[0], 1);
            chk("lock_l1", lockq[1], 0);
        end
        wait_idle("lock_done");

        // start timeout
        dead_mode = 1;
        err_seen = 0;
        set_req(2, 8'h5A, 1'b1);
        k = 0;
        while (!err_seen && k < 100) begin
            step();
            if (m_acc_w >= 0) req_valid[m_acc_w] = 1'b0;
            k++;
        end
        if (k >= 100) expire("to_error_rise");
        chk("to_delay", err_cyc - send_cyc, T + 1);
        chk("to_active", int'(active), 0);
        dead_mode = 0;
        bytes.delete();
        set_req(3, 8'h77, 1'b1);
        k = 0;
        while (bytes.size() < 1 && k < 100) begin
            step();
            if (m_acc_w >= 0) req_valid[m_acc_w] = 1'b0;
            k++;
        end
        if (k >= 100) expire("to_next_send");
        if (bytes.size() >= 1) chk("to_next_data", bytes[0], 'h77);
        chk("to_error_sticky", int'(error), 1);
        wait_idle("to_done");

        // reset while a locked frame is in flight
        tx_len_fix = 10;
        set_req(0, 8'hE0, 1'b0);
        k = 0;
        while (!tx_busy && k < 50) begin
            step();
            if (m_acc_w == 0) set_req(0, 8'hE1, 1'b1);
            k++;
        end
        if (k >= 50) expire("mid_busy");
        step();
        chk("mid_locked_before", int'(locked), 1);
        reset = 1'b1;
        step();
        reset = 1'b0;
        @(negedge clk);
        chk("mid_locked", int'(locked), 0);
        chk("mid_active", int'(active), 0);
        chk("mid_error", int'(error), 0);
        chk("mid_data", int'(tx_data), 0);
        chk("mid_ready", int'(req_ready), 0);
        k = 0;
        while (req_valid[0] && k < 100) begin
            step();
            if (m_acc_w == 0) req_valid[0] = 1'b0;
            k++;
        end
        if (k >= 100) expire("mid_served");
        tx_len_fix = 0;
        wait_idle("mid_done");

        // random traffic
        rand_req = 1;
        rand_dead = 1;
        repeat (1500) step();
        rand_req = 0;
        rand_dead = 0;
        reset = 1'b0;
        req_valid = '0;
        wait_idle("rand_done");
        step();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
